// File: rtl/vl_stim_pkg.sv
// Shared constants, value codes and FSM encoding for the seeded stimulus generator.
package vl_stim_pkg;

  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
  localparam int          WIDTH_MAX = 15;

  typedef enum logic [1:0] {
    V0 = 2'b00,
    V1 = 2'b01,
    VX = 2'b10,
    VZ = 2'b11
  } vcode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } fsm_e;

  // A zero seed would lock the LFSR at zero forever.
  function automatic logic [31:0] seed_fix(input logic [31:0] s);
    return (s == 32'h0) ? 32'h1 : s;
  endfunction

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/vl_stim_gen_if.sv
// Control/status and stimulus bundle between vl_stim_gen and its consumers.
interface vl_stim_gen_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [15:0]      nsteps;
  logic             busy;
  logic             done;
  logic [15:0]      step_cnt;
  logic [WIDTH-1:0] d_val;
  logic [WIDTH-1:0] d_xz;
  logic             dut_clk;

  modport master (
    input  start, nsteps,
    output busy, done, step_cnt, d_val, d_xz, dut_clk
  );

  modport slave (
    output start, nsteps,
    input  busy, done, step_cnt, d_val, d_xz, dut_clk
  );
endinterface

// File: rtl/vl_stim_lfsr.sv
// 32-bit Galois LFSR with enable and synchronous seed load.
// Latency: new state visible one clk after an enabled edge; no backpressure.
// Backpressure: none; holds state while en is low.
module vl_stim_lfsr
  import vl_stim_pkg::*;
#(
  parameter logic [31:0] SEED = 32'h1
) (
  input  logic        clk,
  input  logic        load,
  input  logic        en,
  output logic [31:0] state
);

  always_ff @(posedge clk) begin
    if (load) begin
      state <= seed_fix(SEED);
    end else if (en) begin
      state <= lfsr_next(state);
    end
  end

endmodule

// File: rtl/vl_stim_gen.sv
// Seeded stimulus source: WIDTH-bit data planes plus a DUT clock that never toggles with data.
// Latency: data after start edge +1, dut_clk after +2; busy for nsteps*PERIOD clk. Build option VL_STIM_FOURVAL_EN.
// Backpressure: none; start is ignored unless idle.
module vl_stim_gen
  import vl_stim_pkg::*;
#(
  parameter int          WIDTH  = 4,
  parameter int          PERIOD = 3,
  parameter logic [31:0] SEED   = 32'h1
) (
  input  logic           clk,
  input  logic           rst_n,
  vl_stim_gen_if.master  bus
);

  localparam logic [1:0] IDLE = ST_IDLE;
  localparam logic [1:0] RUN  = ST_RUN;
  localparam logic [1:0] DONE = ST_DONE;
  localparam int         PW   = $clog2(PERIOD);
  localparam logic [PW-1:0] PH_LAST = PW'(PERIOD - 1);

  if (WIDTH < 1 || WIDTH > WIDTH_MAX || PERIOD < 3) begin : g_bad_param
    $error("vl_stim_gen: WIDTH must be 1..15 and PERIOD at least 3");
  end

  logic [1:0]       state;
  logic [PW-1:0]    phase;
  logic [15:0]      nsteps_q;
  logic [15:0]      step_cnt;
  logic [15:0]      step_nxt;
  logic             busy;
  logic             t_bit;
  logic             dut_clk;
  logic [WIDTH-1:0] d_val;
  logic [WIDTH-1:0] d_xz;
  logic [WIDTH-1:0] nxt_val;
  logic [WIDTH-1:0] nxt_xz;
  logic [31:0]      lfsr;
  logic             unused_lfsr;

  vl_stim_lfsr #(.SEED(SEED)) u_lfsr (
    .clk   (clk),
    .load  (!rst_n),
    .en    (busy),
    .state (lfsr)
  );

  // Bit i draws its two-bit code from lfsr[2i+2:2i+1]; lfsr[0] is kept for dut_clk.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
`ifdef VL_STIM_FOURVAL_EN
    vcode_e code;
    assign code       = vcode_e'(lfsr[2*i+1 +: 2]);
    assign nxt_val[i] = (code == V1) || (code == VZ);
    assign nxt_xz[i]  = (code == VX) || (code == VZ);
`else
    assign nxt_val[i] = lfsr[2*i+1];
    assign nxt_xz[i]  = 1'b0;
`endif
  end

  assign unused_lfsr = ^lfsr;
  assign step_nxt    = step_cnt + 16'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      phase    <= '0;
      nsteps_q <= '0;
      step_cnt <= '0;
      busy     <= 1'b0;
      t_bit    <= 1'b0;
      dut_clk  <= 1'b0;
      d_val    <= '0;
      d_xz     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            nsteps_q <= bus.nsteps;
            step_cnt <= '0;
            phase    <= '0;
            if (bus.nsteps == 16'd0) begin
              state <= DONE;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (phase == '0) begin
            d_val <= nxt_val;
            d_xz  <= nxt_xz;
            t_bit <= lfsr[0];
          end
          if (phase == PW'(1)) begin
            dut_clk <= t_bit;
          end
          if (phase == PH_LAST) begin
            step_cnt <= step_nxt;
            // Ending on equality lets nsteps=65535 finish without wrapping.
            if (step_nxt == nsteps_q) begin
              busy  <= 1'b0;
              state <= DONE;
            end else begin
              phase <= '0;
            end
          end else begin
            phase <= phase + PW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy     = busy;
  assign bus.done     = (state == DONE);
  assign bus.step_cnt = step_cnt;
  assign bus.d_val    = d_val;
  assign bus.d_xz     = d_xz;
  assign bus.dut_clk  = dut_clk;

endmodule
